sfu_pack: RTL and testbench

SFU_PACK -- requirements
Module: sfu_pack

---
 rtl/sfu_pack_if.sv | 28 ++
 rtl/sfu_pack.sv | 90 +++++++++
 tb/tb_sfu_pack.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sfu_pack_if.sv
// Pack-stage bus: psum sample input with valid/ready, packed word output with valid/ready.
// The master drives samples and out_ready; the slave (sfu_pack) returns in_ready and the packed word.
interface sfu_pack_if #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 4
);
    logic signed [psum_bw-1:0] psum_in;
    logic                      in_valid;
    logic                      in_ready;
    logic [3:0]                shift;
    logic                      flush;
    logic [bw*col-1:0]         out_data;
    logic [addr_bw-1:0]        out_addr;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output psum_in, in_valid, shift, flush, out_ready,
        input  in_ready, out_data, out_addr, out_valid
    );

    modport slave (
        input  psum_in, in_valid, shift, flush, out_ready,
        output in_ready, out_data, out_addr, out_valid
    );
endinterface

// File: rtl/sfu_pack.sv
// Requantizes ReLU'd psums to bw bits and packs col lanes per word; word valid one cycle after completing accept.
// While a word is held (out_ready low) in_ready is low and flushes are dropped; in_ready depends on state only.
module sfu_pack #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      clear,
    sfu_pack_if.slave bus
);
    localparam int LW = (col > 1) ? $clog2(col) : 1;
    localparam logic signed [psum_bw-1:0] QMAX = psum_bw'((1 << bw) - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                    state_q;
    logic [LW-1:0]             lane_q;
    logic [bw*col-1:0]         stage_q;
    logic [bw*col-1:0]         out_data_q;
    logic [addr_bw-1:0]        out_addr_q;

    logic signed [psum_bw-1:0] shifted;
    logic [bw-1:0]             q_lane;
    logic [bw*col-1:0]         stage_d;
    logic                      accept;
    logic                      last_lane;
    logic                      emit;

    always_comb begin
        shifted = bus.psum_in >>> bus.shift;
        q_lane  = '0;
        if (shifted < 0) begin
            q_lane = '0;
        end else if (shifted > QMAX) begin
            q_lane = '1;
        end else begin
            q_lane = shifted[bw-1:0];
        end

        stage_d = stage_q;
        stage_d[int'(lane_q)*bw +: bw] = q_lane;

        accept    = bus.in_valid && (state_q == COLLECT);
        last_lane = (lane_q == LW'(col - 1));
        // A same-cycle sample lands before the flush; an empty staging word only emits if that sample exists.
        emit      = (state_q == COLLECT) &&
                    ((accept && last_lane) || (bus.flush && (accept || lane_q != '0)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= COLLECT;
            lane_q     <= '0;
            stage_q    <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else if (clear) begin
            state_q    <= COLLECT;
            lane_q     <= '0;
            stage_q    <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else if (state_q == HOLD) begin
            if (bus.out_ready) begin
                state_q    <= COLLECT;
                out_addr_q <= out_addr_q + addr_bw'(1);
            end
        end else if (emit) begin
            // Staging is zeroed on every emit so later partial words carry no stale lanes.
            out_data_q <= accept ? stage_d : stage_q;
            stage_q    <= '0;
            lane_q     <= '0;
            state_q    <= HOLD;
        end else if (accept) begin
            stage_q <= stage_d;
            lane_q  <= lane_q + LW'(1);
        end
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
endmodule

// File: tb/tb_sfu_pack.sv
// Bench for sfu_pack (addr_bw=2): directed scenarios plus randomized traffic against a lane-queue model.
module tb_sfu_pack;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    sfu_pack_if #(.bw(4), .psum_bw(16), .col(8), .addr_bw(2)) pif ();

    sfu_pack #(.bw(4), .psum_bw(16), .col(8), .addr_bw(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (pif)
    );

    always #5 clk = ~clk;

    // Reference model: pending lane values, held word, hold flag, address.
    int          m_q[$];
    logic [31:0] m_word;
    logic        m_hold;
    int          m_addr;

    function automatic int quant(input logic [15:0] p, input int s);
        int v;
        v = int'($signed(p));
        if (v < 0) return 0;
        v = v / (1 << s);
        if (v > 15) return 15;
        return v;
    endfunction

    function automatic logic [31:0] pack_lanes();
        logic [31:0] w;
        w = '0;
        foreach (m_q[i]) w[4*i +: 4] = m_q[i][3:0];
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_word = '0;
        m_hold = 1'b0;
        m_addr = 0;
    endtask

    task automatic step(input logic v, input logic [15:0] p, input logic [3:0] s,
                        input logic f, input logic ordy, input logic clr);
        pif.in_valid  = v;
        pif.psum_in   = p;
        pif.shift     = s;
        pif.flush     = f;
        pif.out_ready = ordy;
        clear         = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (m_hold) begin
            if (ordy) begin
                m_hold = 1'b0;
                m_addr = (m_addr + 1) % 4;
            end
        end else begin
            if (v) m_q.push_back(quant(p, int'(s)));
            if (m_q.size() == 8 || (f && m_q.size() > 0)) begin
                m_word = pack_lanes();
                m_q.delete();
                m_hold = 1'b1;
            end
        end
        #1;
    endtask

    task automatic assert_reset();
        pif.in_valid  = 1'b0;
        pif.flush     = 1'b0;
        pif.out_ready = 1'b0;
        clear         = 1'b0;
        reset_n       = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        n_tests++; if (pif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", pif.in_ready); end
        n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", pif.out_valid); end
        n_tests++; if (pif.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", pif.out_data); end
        n_tests++; if (pif.out_addr !== 2'd0) begin n_fail++; $display("FAIL reset_out_addr got %0d want 0", pif.out_addr); end
        release_reset();
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 4'd0, 1'b0, 1'b1, 1'b0);
            if (i < 8) begin
                n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid lane %0d got %b want 0", i, pif.out_valid); end
            end
        end
        n_tests++; if (pif.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", pif.out_valid); end
        n_tests++; if (pif.out_data !== 32'h87654321) begin n_fail++; $display("FAIL basic_data got %h want 87654321", pif.out_data); end
        n_tests++; if (pif.out_addr !== 2'd0) begin n_fail++; $display("FAIL basic_addr got %0d want 0", pif.out_addr); end
        n_tests++; if (pif.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_in_ready got %b want 0", pif.in_ready); end
        step(1'b0, 16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle got %b want 0", pif.out_valid); end
        n_tests++; if (pif.out_addr !== 2'd1) begin n_fail++; $display("FAIL basic_addr_inc got %0d want 1", pif.out_addr); end
    endtask

    task automatic test_clamp();
        step(1'b1, 16'h0100, 4'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0030, 4'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hFFF0, 4'd4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pif.out_data !== 32'h0000003F) begin n_fail++; $display("FAIL clamp_data got %h want 0000003f", pif.out_data); end
        n_tests++; if (pif.out_valid !== 1'b1) begin n_fail++; $display("FAIL clamp_valid got %b want 1", pif.out_valid); end
        step(1'b0, 16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom_range(0, 255)), 4'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 16'h0007, 4'd0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({pif.out_valid, pif.in_ready, pif.out_addr, pif.out_data} !== {1'b1, 1'b0, 2'(m_addr), m_word}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got v=%b r=%b a=%0d d=%h want v=1 r=0 a=%0d d=%h",
                         c, pif.out_valid, pif.in_ready, pif.out_addr, pif.out_data, m_addr, m_word);
            end
        end
        step(1'b1, 16'h0007, 4'd0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", pif.out_valid); end
        step(1'b1, 16'h0005, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pif.out_data !== 32'h00000005) begin n_fail++; $display("FAIL bp_not_consumed got %h want 00000005", pif.out_data); end
        step(1'b0, 16'h0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        step(1'b1, 16'd5, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd6, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd7, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pif.out_data !== 32'h00000765) begin n_fail++; $display("FAIL flush_partial got %h want 00000765", pif.out_data); end
        // Flush while holding must be dropped, not queued.
        step(1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_in_hold_queued got %b want 0", pif.out_valid); end
        step(1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %b want 0", pif.out_valid); end
        step(1'b1, 16'd2, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd9, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pif.out_data !== 32'h00000092) begin n_fail++; $display("FAIL flush_with_sample got %h want 00000092", pif.out_data); end
        step(1'b0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(9 - i), 4'd0, (i == 8), 1'b0, 1'b0);
        n_tests++; if (pif.out_data !== 32'h12345678) begin n_fail++; $display("FAIL flush_on_complete got %h want 12345678", pif.out_data); end
        step(1'b0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_on_complete_extra got %b want 0", pif.out_valid); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_addr [5];
        exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        assert_reset();
        release_reset();
        for (int w = 0; w < 5; w++) begin
            step(1'b1, 16'(w + 1), 4'd0, 1'b1, 1'b0, 1'b0);
            n_tests++; if (pif.out_addr !== exp_addr[w]) begin n_fail++; $display("FAIL wrap_addr word %0d got %0d want %0d", w, pif.out_addr, exp_addr[w]); end
            step(1'b0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 16'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        assert_reset();
        n_tests++;
        if ({pif.out_valid, pif.in_ready, pif.out_addr, pif.out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            n_fail++; $display("FAIL reset_mid_word got v=%b r=%b a=%0d d=%h want 0 1 0 0", pif.out_valid, pif.in_ready, pif.out_addr, pif.out_data);
        end
        release_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 4'd0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({pif.out_valid, pif.out_addr, pif.out_data} !== {1'b1, 2'd0, 32'h87654321}) begin
            n_fail++; $display("FAIL reset_mid_next_word got v=%b a=%0d d=%h want 1 0 87654321", pif.out_valid, pif.out_addr, pif.out_data);
        end
        assert_reset();
        n_tests++;
        if ({pif.out_valid, pif.in_ready, pif.out_addr, pif.out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            n_fail++; $display("FAIL reset_in_hold got v=%b r=%b a=%0d d=%h want 0 1 0 0", pif.out_valid, pif.in_ready, pif.out_addr, pif.out_data);
        end
        release_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 16'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd15, 4'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pif.out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_discard got %b want 0", pif.out_valid); end
        step(1'b1, 16'd3, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pif.out_data !== 32'h00000003) begin n_fail++; $display("FAIL clear_no_stale got %h want 00000003", pif.out_data); end
        step(1'b0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 4) != 0, 16'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom % 6) == 0, ($urandom % 2) == 0, ($urandom % 80) == 0);
            n_tests++;
            if ({pif.out_valid, pif.in_ready, pif.out_addr, pif.out_data} !== {m_hold, ~m_hold, 2'(m_addr), m_word}) begin
                n_fail++;
                $display("FAIL random cycle %0d got v=%b r=%b a=%0d d=%h want v=%b r=%b a=%0d d=%h",
                         c, pif.out_valid, pif.in_ready, pif.out_addr, pif.out_data, m_hold, ~m_hold, m_addr, m_word);
            end
        end
    endtask

    initial begin
        pif.in_valid  = 1'b0;
        pif.psum_in   = '0;
        pif.shift     = '0;
        pif.flush     = 1'b0;
        pif.out_ready = 1'b0;
        model_reset();
        #12;
        test_reset();
        test_basic();
        test_clamp();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
